// File: rtl/lieat_exu_bpuresolve_if.sv
// Predictor-training bundle: IFU predictions and EXU resolutions in; callback, redirect and status out.
// The master modport is the IFU/EXU side. The slave modport is the resolve tracker.
interface lieat_exu_bpuresolve_if #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5,
    parameter int PC_W  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic             pred_ready;
    logic [IDX_W-1:0] pred_index;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_alt_pc;
    logic             res_valid;
    logic             res_taken;
    logic             ext_flush;
    logic             callback_en;
    logic [IDX_W-1:0] callback_index;
    logic             callback_result;
    logic             flush_req;
    logic [PC_W-1:0]  flush_pc;
    logic             res_err;
    logic [CNT_W-1:0] count;
    logic [15:0]      misp_cnt;

    modport master (
        output pred_valid, pred_index, pred_taken, pred_alt_pc,
        output res_valid, res_taken, ext_flush,
        input  pred_ready, callback_en, callback_index, callback_result,
        input  flush_req, flush_pc, res_err, count, misp_cnt
    );

    modport slave (
        input  pred_valid, pred_index, pred_taken, pred_alt_pc,
        input  res_valid, res_taken, ext_flush,
        output pred_ready, callback_en, callback_index, callback_result,
        output flush_req, flush_pc, res_err, count, misp_cnt
    );
endinterface

// File: rtl/lieat_exu_bpuresolve.sv
// In-order branch-prediction tracker: callback and redirect appear one cycle after a resolve.
// pred_ready depends only on the registered count, so a full queue refuses a push even when it pops.
module lieat_exu_bpuresolve #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    lieat_exu_bpuresolve_if.slave    bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             taken;
        logic [PC_W-1:0]  alt_pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      misp_cnt_q, misp_cnt_d;
    logic             cb_en_q, cb_en_d;
    logic [IDX_W-1:0] cb_idx_q, cb_idx_d;
    logic             cb_res_q, cb_res_d;
    logic             flush_req_q, flush_req_d;
    logic [PC_W-1:0]  flush_pc_q, flush_pc_d;
    logic             res_err_q, res_err_d;
    logic             mem_we;

    logic   pred_ready;
    logic   push_acc;
    logic   pop_acc;
    logic   mispredict;
    entry_t head;
    entry_t wr_entry;

    assign pred_ready = (count_q != CNT_W'(DEPTH));
    assign push_acc   = bus.pred_valid & pred_ready;
    assign pop_acc    = bus.res_valid & (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign mispredict = pop_acc & (head.taken ^ bus.res_taken);
    assign wr_entry   = '{index: bus.pred_index, taken: bus.pred_taken, alt_pc: bus.pred_alt_pc};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        misp_cnt_d  = misp_cnt_q;
        cb_en_d     = 1'b0;
        cb_idx_d    = cb_idx_q;
        cb_res_d    = cb_res_q;
        flush_req_d = 1'b0;
        flush_pc_d  = flush_pc_q;
        res_err_d   = 1'b0;
        mem_we      = 1'b0;

        if (bus.ext_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            res_err_d = bus.res_valid & (count_q == '0);
            if (pop_acc) begin
                cb_en_d  = 1'b1;
                cb_idx_d = head.index;
                cb_res_d = bus.res_taken;
            end
            if (mispredict) begin
                // Everything younger than the head is wrong-path, including a same-cycle push.
                rd_ptr_d    = wr_ptr_q;
                count_d     = '0;
                flush_req_d = 1'b1;
                flush_pc_d  = head.alt_pc;
                if (misp_cnt_q != 16'hFFFF) begin
                    misp_cnt_d = misp_cnt_q + 16'd1;
                end
            end else begin
                if (push_acc) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (pop_acc) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            misp_cnt_q  <= '0;
            cb_en_q     <= 1'b0;
            cb_idx_q    <= '0;
            cb_res_q    <= 1'b0;
            flush_req_q <= 1'b0;
            flush_pc_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            if (mem_we) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            misp_cnt_q  <= misp_cnt_d;
            cb_en_q     <= cb_en_d;
            cb_idx_q    <= cb_idx_d;
            cb_res_q    <= cb_res_d;
            flush_req_q <= flush_req_d;
            flush_pc_q  <= flush_pc_d;
            res_err_q   <= res_err_d;
        end
    end

    assign bus.pred_ready      = pred_ready;
    assign bus.callback_en     = cb_en_q;
    assign bus.callback_index  = cb_idx_q;
    assign bus.callback_result = cb_res_q;
    assign bus.flush_req       = flush_req_q;
    assign bus.flush_pc        = flush_pc_q;
    assign bus.res_err         = res_err_q;
    assign bus.count           = count_q;
    assign bus.misp_cnt        = misp_cnt_q;
endmodule

// File: tb/tb_lieat_exu_bpuresolve.sv
// Directed bench for the branch-resolution tracker; each task drives one scenario and checks it inline.
module tb_lieat_exu_bpuresolve;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lieat_exu_bpuresolve_if bus ();

    lieat_exu_bpuresolve dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pred_valid  = 1'b0;
        bus.pred_index  = '0;
        bus.pred_taken  = 1'b0;
        bus.pred_alt_pc = '0;
        bus.res_valid   = 1'b0;
        bus.res_taken   = 1'b0;
        bus.ext_flush   = 1'b0;
    endtask

    task automatic set_push(input int idx, input bit tk, input logic [31:0] alt);
        bus.pred_valid  = 1'b1;
        bus.pred_index  = 5'(idx);
        bus.pred_taken  = tk;
        bus.pred_alt_pc = alt;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (bus.callback_en !== 1'b0) begin errors++; $display("FAIL rst_cb_en got %0b want 0", bus.callback_en); end
        checks++; if (bus.callback_index !== 5'd0) begin errors++; $display("FAIL rst_cb_idx got %0d want 0", bus.callback_index); end
        checks++; if (bus.callback_result !== 1'b0) begin errors++; $display("FAIL rst_cb_res got %0b want 0", bus.callback_result); end
        checks++; if (bus.flush_req !== 1'b0) begin errors++; $display("FAIL rst_flush_req got %0b want 0", bus.flush_req); end
        checks++; if (bus.flush_pc !== 32'h0) begin errors++; $display("FAIL rst_flush_pc got %0h want 0", bus.flush_pc); end
        checks++; if (bus.res_err !== 1'b0) begin errors++; $display("FAIL rst_res_err got %0b want 0", bus.res_err); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.count); end
        checks++; if (bus.misp_cnt !== 16'h0) begin errors++; $display("FAIL rst_misp got %0h want 0", bus.misp_cnt); end
        rst = 1'b0;
        cyc();
        checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", bus.pred_ready); end
    endtask

    task automatic test_correct();
        set_push(3, 1'b1, 32'h100);
        cyc();
        idle();
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL corr_count1 got %0d want 1", bus.count); end
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        cyc();
        idle();
        checks++; if (bus.callback_en !== 1'b1) begin errors++; $display("FAIL corr_cb_en got %0b want 1", bus.callback_en); end
        checks++; if (bus.callback_index !== 5'd3) begin errors++; $display("FAIL corr_cb_idx got %0d want 3", bus.callback_index); end
        checks++; if (bus.callback_result !== 1'b1) begin errors++; $display("FAIL corr_cb_res got %0b want 1", bus.callback_result); end
        checks++; if (bus.flush_req !== 1'b0) begin errors++; $display("FAIL corr_flush_req got %0b want 0", bus.flush_req); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL corr_count0 got %0d want 0", bus.count); end
        cyc();
        checks++; if (bus.callback_en !== 1'b0) begin errors++; $display("FAIL corr_pulse got %0b want 0", bus.callback_en); end
        checks++; if (bus.callback_index !== 5'd3) begin errors++; $display("FAIL corr_hold_idx got %0d want 3", bus.callback_index); end
    endtask

    task automatic test_mispredict();
        set_push(7, 1'b0, 32'h2000);
        cyc();
        set_push(8, 1'b1, 32'h3000);
        cyc();
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL misp_count2 got %0d want 2", bus.count); end
        set_push(9, 1'b0, 32'h4000);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        cyc();
        idle();
        checks++; if (bus.callback_en !== 1'b1) begin errors++; $display("FAIL misp_cb_en got %0b want 1", bus.callback_en); end
        checks++; if (bus.callback_index !== 5'd7) begin errors++; $display("FAIL misp_cb_idx got %0d want 7", bus.callback_index); end
        checks++; if (bus.callback_result !== 1'b1) begin errors++; $display("FAIL misp_cb_res got %0b want 1", bus.callback_result); end
        checks++; if (bus.flush_req !== 1'b1) begin errors++; $display("FAIL misp_flush_req got %0b want 1", bus.flush_req); end
        checks++; if (bus.flush_pc !== 32'h2000) begin errors++; $display("FAIL misp_flush_pc got %0h want 2000", bus.flush_pc); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL misp_count got %0d want 0", bus.count); end
        checks++; if (bus.misp_cnt !== 16'd1) begin errors++; $display("FAIL misp_cnt got %0d want 1", bus.misp_cnt); end
        checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("FAIL misp_ready got %0b want 1", bus.pred_ready); end
        set_push(10, 1'b0, 32'h5000);
        cyc();
        idle();
        checks++; if (bus.flush_req !== 1'b0) begin errors++; $display("FAIL misp_pulse got %0b want 0", bus.flush_req); end
        checks++; if (bus.flush_pc !== 32'h2000) begin errors++; $display("FAIL misp_hold_pc got %0h want 2000", bus.flush_pc); end
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        cyc();
        idle();
        checks++; if (bus.callback_index !== 5'd10) begin errors++; $display("FAIL misp_after_idx got %0d want 10", bus.callback_index); end
        checks++; if (bus.flush_req !== 1'b0) begin errors++; $display("FAIL misp_after_flush got %0b want 0", bus.flush_req); end
    endtask

    task automatic test_full_wrap();
        int exp_q[$];
        int want;
        for (int i = 0; i < 4; i++) begin
            set_push(11 + i, 1'b0, 32'h600 + 32'(i));
            exp_q.push_back(11 + i);
            cyc();
        end
        idle();
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", bus.count); end
        checks++; if (bus.pred_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", bus.pred_ready); end
        set_push(15, 1'b0, 32'h700);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        cyc();
        idle();
        want = exp_q.pop_front();
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_refuse_count got %0d want 3", bus.count); end
        checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %0b want 1", bus.pred_ready); end
        checks++; if (bus.callback_index !== 5'(want)) begin errors++; $display("FAIL full_pop_idx got %0d want %0d", bus.callback_index, want); end
        for (int r = 0; r < 8; r++) begin
            set_push(20 + r, 1'b0, 32'h800 + 32'(r));
            exp_q.push_back(20 + r);
            bus.res_valid = 1'b1;
            bus.res_taken = 1'b0;
            cyc();
            idle();
            want = exp_q.pop_front();
            checks++; if (bus.callback_en !== 1'b1 || bus.callback_index !== 5'(want)) begin errors++; $display("FAIL wrap_idx r=%0d got en=%0b idx=%0d want en=1 idx=%0d", r, bus.callback_en, bus.callback_index, want); end
            checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL wrap_count r=%0d got %0d want 3", r, bus.count); end
        end
        for (int d = 0; d < 3; d++) begin
            bus.res_valid = 1'b1;
            bus.res_taken = 1'b0;
            cyc();
            idle();
            want = exp_q.pop_front();
            checks++; if (bus.callback_index !== 5'(want)) begin errors++; $display("FAIL drain_idx d=%0d got %0d want %0d", d, bus.callback_index, want); end
        end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d want 0", bus.count); end
    endtask

    task automatic test_empty_res();
        set_push(2, 1'b1, 32'h900);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        cyc();
        idle();
        checks++; if (bus.res_err !== 1'b1) begin errors++; $display("FAIL empty_err got %0b want 1", bus.res_err); end
        checks++; if (bus.callback_en !== 1'b0) begin errors++; $display("FAIL empty_cb_en got %0b want 0", bus.callback_en); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL empty_count got %0d want 1", bus.count); end
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        cyc();
        idle();
        checks++; if (bus.res_err !== 1'b0) begin errors++; $display("FAIL empty_err_pulse got %0b want 0", bus.res_err); end
        checks++; if (bus.callback_index !== 5'd2) begin errors++; $display("FAIL empty_later_idx got %0d want 2", bus.callback_index); end
        checks++; if (bus.flush_req !== 1'b0) begin errors++; $display("FAIL empty_later_flush got %0b want 0", bus.flush_req); end
    endtask

    task automatic test_ext_flush();
        set_push(4, 1'b0, 32'hA00);
        cyc();
        set_push(5, 1'b0, 32'hB00);
        cyc();
        set_push(6, 1'b0, 32'hC00);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        bus.ext_flush = 1'b1;
        cyc();
        idle();
        checks++; if (bus.callback_en !== 1'b0) begin errors++; $display("FAIL xf_cb_en got %0b want 0", bus.callback_en); end
        checks++; if (bus.flush_req !== 1'b0) begin errors++; $display("FAIL xf_flush_req got %0b want 0", bus.flush_req); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL xf_count got %0d want 0", bus.count); end
        checks++; if (bus.misp_cnt !== 16'd1) begin errors++; $display("FAIL xf_misp got %0d want 1", bus.misp_cnt); end
        set_push(17, 1'b1, 32'hD00);
        cyc();
        idle();
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        cyc();
        idle();
        checks++; if (bus.callback_index !== 5'd17) begin errors++; $display("FAIL xf_after_idx got %0d want 17", bus.callback_index); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            set_push(1 + i, 1'b0, 32'hE00 + 32'(i));
            cyc();
        end
        idle();
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        cyc();
        idle();
        checks++; if (bus.callback_en !== 1'b1 || bus.count !== 3'd0) begin errors++; $display("FAIL mid_pre got en=%0b cnt=%0d want en=1 cnt=0", bus.callback_en, bus.count); end
        for (int i = 0; i < 3; i++) begin
            set_push(1 + i, 1'b0, 32'hF00);
            cyc();
        end
        set_push(9, 1'b0, 32'hF00);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        cyc();
        idle();
        checks++; if (bus.callback_en !== 1'b1 || bus.count !== 3'd3) begin errors++; $display("FAIL mid_setup got en=%0b cnt=%0d want en=1 cnt=3", bus.callback_en, bus.count); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (bus.callback_en !== 1'b0) begin errors++; $display("FAIL mid_cb_en got %0b want 0", bus.callback_en); end
        checks++; if (bus.callback_index !== 5'd0) begin errors++; $display("FAIL mid_cb_idx got %0d want 0", bus.callback_index); end
        checks++; if (bus.flush_pc !== 32'h0) begin errors++; $display("FAIL mid_flush_pc got %0h want 0", bus.flush_pc); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", bus.count); end
        checks++; if (bus.misp_cnt !== 16'd0) begin errors++; $display("FAIL mid_misp got %0d want 0", bus.misp_cnt); end
        checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b want 1", bus.pred_ready); end
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        cyc();
        idle();
        checks++; if (bus.res_err !== 1'b1 || bus.callback_en !== 1'b0) begin errors++; $display("FAIL mid_killed got err=%0b en=%0b want err=1 en=0", bus.res_err, bus.callback_en); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.misp_cnt_d = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.misp_cnt_d;
        checks++; if (bus.misp_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_load got %0h want ffff", bus.misp_cnt); end
        set_push(12, 1'b1, 32'h1234);
        cyc();
        idle();
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        cyc();
        idle();
        checks++; if (bus.flush_req !== 1'b1 || bus.flush_pc !== 32'h1234) begin errors++; $display("FAIL sat_flush got req=%0b pc=%0h want req=1 pc=1234", bus.flush_req, bus.flush_pc); end
        checks++; if (bus.callback_result !== 1'b0) begin errors++; $display("FAIL sat_cb_res got %0b want 0", bus.callback_result); end
        checks++; if (bus.misp_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %0h want ffff", bus.misp_cnt); end
    endtask

    initial begin
        idle();
        test_reset();
        test_correct();
        test_mispredict();
        test_full_wrap();
        test_empty_res();
        test_ext_flush();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
